// File: rtl/x4xx_mgt_mon_pkg.sv
// Shared types and constants for the MGT lane link monitor.
// Register field selects, per-lane link state encoding and the bad-lane read signature.
package x4xx_mgt_mon_pkg;

    typedef enum logic [1:0] {
        MON_STATUS    = 2'd0,
        MON_RX_PKT    = 2'd1,
        MON_TX_PKT    = 2'd2,
        MON_LINK_DOWN = 2'd3
    } mon_field_e;

    typedef enum logic [1:0] {
        LANE_DOWN = 2'd0,
        LANE_QUAL = 2'd1,
        LANE_UP   = 2'd2
    } lane_state_e;

    localparam logic [15:0] MON_BAD_LANE_SIG = 16'hDEAD;

endpackage

// File: rtl/x4xx_mgt_lane_mon.sv
// One MGT lane: link debounce FSM, traffic activity stretcher and packet/link-drop counters.
// Link loss is reported on the next edge; qualification needs DEBOUNCE_CYCLES consecutive highs.
module x4xx_mgt_lane_mon
    import x4xx_mgt_mon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int ACT_HOLD_CYCLES = 2**20,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_link_up,
    input  logic             rx_beat,
    input  logic             rx_last,
    input  logic             tx_beat,
    input  logic             tx_last,
    input  logic             clr,
    output logic             link_up,
    output logic             activity,
    output logic [CNT_W-1:0] rx_pkt_cnt,
    output logic [CNT_W-1:0] tx_pkt_cnt,
    output logic [CNT_W-1:0] link_down_cnt
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(ACT_HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ACT_HOLD_CYCLES);

    lane_state_e       state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              link_lost;

    assign link_lost = (state == LANE_UP) && !raw_link_up;

    // A beat reloads the hold timer even on the cycle it would have reached zero.
    always_comb begin
        hold_nxt = hold_cnt;
        if (rx_beat || tx_beat)
            hold_nxt = HOLD_LOAD;
        else if (hold_cnt != '0)
            hold_nxt = hold_cnt - HOLD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LANE_DOWN;
            deb_cnt       <= '0;
            link_up       <= 1'b0;
            hold_cnt      <= '0;
            activity      <= 1'b0;
            rx_pkt_cnt    <= '0;
            tx_pkt_cnt    <= '0;
            link_down_cnt <= '0;
        end else begin
            case (state)
                LANE_DOWN, LANE_QUAL: begin
                    if (!raw_link_up) begin
                        state   <= LANE_DOWN;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= LANE_UP;
                        link_up <= 1'b1;
                        deb_cnt <= '0;
                    end else begin
                        state   <= LANE_QUAL;
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                LANE_UP: begin
                    if (!raw_link_up) begin
                        state   <= LANE_DOWN;
                        link_up <= 1'b0;
                    end
                end
                default: begin
                    state   <= LANE_DOWN;
                    link_up <= 1'b0;
                    deb_cnt <= '0;
                end
            endcase

            hold_cnt <= hold_nxt;
            activity <= (hold_nxt != '0);

            // Clear has priority; an event coincident with it is dropped.
            if (clr) begin
                rx_pkt_cnt    <= '0;
                tx_pkt_cnt    <= '0;
                link_down_cnt <= '0;
            end else begin
                if (rx_beat && rx_last)
                    rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
                if (tx_beat && tx_last)
                    tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
                if (link_lost && (link_down_cnt != '1))
                    link_down_cnt <= link_down_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/x4xx_mgt_link_monitor.sv
// Per-lane MGT link/activity monitor with a single-cycle register read port.
// Lanes are addressed by addr[7:4], fields by addr[3:2]; unknown lanes return a signature word.
module x4xx_mgt_link_monitor
    import x4xx_mgt_mon_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int ACT_HOLD_CYCLES = 2**20,
    parameter int CNT_W           = 32
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic [NUM_LANES-1:0] raw_link_up,
    input  logic [NUM_LANES-1:0] e2v_tvalid,
    input  logic [NUM_LANES-1:0] e2v_tready,
    input  logic [NUM_LANES-1:0] e2v_tlast,
    input  logic [NUM_LANES-1:0] v2e_tvalid,
    input  logic [NUM_LANES-1:0] v2e_tready,
    input  logic [NUM_LANES-1:0] v2e_tlast,
    input  logic                 clr_counters,
    input  logic                 reg_rd_req,
    input  logic [7:0]           reg_rd_addr,
    output logic                 reg_rd_ack,
    output logic [31:0]          reg_rd_data,
    output logic [NUM_LANES-1:0] link_up,
    output logic [NUM_LANES-1:0] activity
);

    logic [CNT_W-1:0] rx_cnt   [NUM_LANES];
    logic [CNT_W-1:0] tx_cnt   [NUM_LANES];
    logic [CNT_W-1:0] down_cnt [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        x4xx_mgt_lane_mon #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACT_HOLD_CYCLES (ACT_HOLD_CYCLES),
            .CNT_W           (CNT_W)
        ) u_lane (
            .clk           (bus_clk),
            .rst           (bus_rst),
            .raw_link_up   (raw_link_up[i]),
            .rx_beat       (e2v_tvalid[i] & e2v_tready[i]),
            .rx_last       (e2v_tlast[i]),
            .tx_beat       (v2e_tvalid[i] & v2e_tready[i]),
            .tx_last       (v2e_tlast[i]),
            .clr           (clr_counters),
            .link_up       (link_up[i]),
            .activity      (activity[i]),
            .rx_pkt_cnt    (rx_cnt[i]),
            .tx_pkt_cnt    (tx_cnt[i]),
            .link_down_cnt (down_cnt[i])
        );
    end

    logic [3:0]  rd_lane;
    mon_field_e  rd_field;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign rd_lane          = reg_rd_addr[7:4];
    assign rd_field         = mon_field_e'(reg_rd_addr[3:2]);
    assign unused_addr_bits = ^reg_rd_addr[1:0];

    always_comb begin
        rd_word = {MON_BAD_LANE_SIG, 16'(NUM_LANES)};
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rd_lane == 4'(i)) begin
                case (rd_field)
                    MON_STATUS:    rd_word = {30'b0, activity[i], link_up[i]};
                    MON_RX_PKT:    rd_word = 32'(rx_cnt[i]);
                    MON_TX_PKT:    rd_word = 32'(tx_cnt[i]);
                    MON_LINK_DOWN: rd_word = 32'(down_cnt[i]);
                    default:       rd_word = '0;
                endcase
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            reg_rd_ack  <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            reg_rd_ack <= reg_rd_req;
            if (reg_rd_req)
                reg_rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_x4xx_mgt_link_monitor.sv
// Directed bench for x4xx_mgt_link_monitor: a 32-bit-counter instance and a 2-bit-counter
// instance share the same stimulus so wrap and saturation can be seen side by side.
module tb_x4xx_mgt_link_monitor;

    localparam int NL = 4;

    logic          bus_clk = 1'b0;
    logic          bus_rst;
    logic [NL-1:0] raw_link_up;
    logic [NL-1:0] e2v_tvalid, e2v_tready, e2v_tlast;
    logic [NL-1:0] v2e_tvalid, v2e_tready, v2e_tlast;
    logic          clr_counters;
    logic          reg_rd_req;
    logic [7:0]    reg_rd_addr;

    logic          a_ack, b_ack;
    logic [31:0]   a_data, b_data;
    logic [NL-1:0] a_link_up, b_link_up, a_activity, b_activity;

    int checks = 0;
    int errors = 0;

    always #5 bus_clk = ~bus_clk;

    x4xx_mgt_link_monitor #(
        .NUM_LANES(NL), .DEBOUNCE_CYCLES(16), .ACT_HOLD_CYCLES(8), .CNT_W(32)
    ) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst), .raw_link_up(raw_link_up),
        .e2v_tvalid(e2v_tvalid), .e2v_tready(e2v_tready), .e2v_tlast(e2v_tlast),
        .v2e_tvalid(v2e_tvalid), .v2e_tready(v2e_tready), .v2e_tlast(v2e_tlast),
        .clr_counters(clr_counters), .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
        .reg_rd_ack(a_ack), .reg_rd_data(a_data), .link_up(a_link_up), .activity(a_activity)
    );

    x4xx_mgt_link_monitor #(
        .NUM_LANES(NL), .DEBOUNCE_CYCLES(16), .ACT_HOLD_CYCLES(8), .CNT_W(2)
    ) dut_w2 (
        .bus_clk(bus_clk), .bus_rst(bus_rst), .raw_link_up(raw_link_up),
        .e2v_tvalid(e2v_tvalid), .e2v_tready(e2v_tready), .e2v_tlast(e2v_tlast),
        .v2e_tvalid(v2e_tvalid), .v2e_tready(v2e_tready), .v2e_tlast(v2e_tlast),
        .clr_counters(clr_counters), .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
        .reg_rd_ack(b_ack), .reg_rd_data(b_data), .link_up(b_link_up), .activity(b_activity)
    );

    task automatic step(input int n);
        repeat (n) @(posedge bus_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e32, input logic [31:0] e2,
                      input string tag);
        reg_rd_req  = 1'b1;
        reg_rd_addr = a;
        step(1);
        chk({tag, "_ack"}, {31'b0, a_ack}, 32'd1);
        chk(tag, a_data, e32);
        chk({tag, "_w2"}, b_data, e2);
        reg_rd_req = 1'b0;
        step(1);
        chk({tag, "_ack_drop"}, {31'b0, a_ack}, 32'd0);
    endtask

    task automatic rx_pkts(input int ln, input int n);
        for (int k = 0; k < n; k++) begin
            e2v_tvalid[ln] = 1'b1; e2v_tready[ln] = 1'b1; e2v_tlast[ln] = 1'b1;
            step(1);
            e2v_tvalid[ln] = 1'b0; e2v_tready[ln] = 1'b0; e2v_tlast[ln] = 1'b0;
        end
    endtask

    task automatic tx_pkts(input int ln, input int n);
        for (int k = 0; k < n; k++) begin
            v2e_tvalid[ln] = 1'b1; v2e_tready[ln] = 1'b1; v2e_tlast[ln] = 1'b1;
            step(1);
            v2e_tvalid[ln] = 1'b0; v2e_tready[ln] = 1'b0; v2e_tlast[ln] = 1'b0;
        end
    endtask

    task automatic tx_beat0();
        v2e_tvalid[0] = 1'b1; v2e_tready[0] = 1'b1;
        step(1);
        v2e_tvalid[0] = 1'b0; v2e_tready[0] = 1'b0;
    endtask

    logic [7:0]  b2b_addr [4] = '{8'h20, 8'h2C, 8'h50, 8'h34};
    logic [31:0] b2b_exp  [4] = '{32'h1, 32'h0, 32'hDEAD_0004, 32'h4};
    logic [31:0] b2b_exp2 [4] = '{32'h1, 32'h0, 32'hDEAD_0004, 32'h0};

    initial begin
        bus_rst = 1'b1;
        raw_link_up = '0;
        e2v_tvalid = '0; e2v_tready = '0; e2v_tlast = '0;
        v2e_tvalid = '0; v2e_tready = '0; v2e_tlast = '0;
        clr_counters = 1'b0;
        reg_rd_req = 1'b0;
        reg_rd_addr = '0;
        step(3);
        chk("rst_ack", {31'b0, a_ack}, 32'd0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_link", {28'b0, a_link_up}, 32'd0);
        chk("rst_act", {28'b0, a_activity}, 32'd0);
        bus_rst = 1'b0;
        step(1);
        rd(8'h00, 32'h0, 32'h0, "rd_reset_status");

        // Lane 1 debounce, with a glitch during qualification
        raw_link_up[1] = 1'b1; step(10);
        raw_link_up[1] = 1'b0; step(1);
        chk("qual_glitch", {28'b0, a_link_up}, 32'h0);
        raw_link_up[1] = 1'b1; step(15);
        chk("deb_early", {28'b0, a_link_up}, 32'h0);
        step(1);
        chk("deb_up", {28'b0, a_link_up}, 32'h2);
        rd(8'h10, 32'h1, 32'h1, "rd_lane1_status");
        raw_link_up[1] = 1'b0; step(1);
        chk("fast_drop", {28'b0, a_link_up}, 32'h0);
        rd(8'h1C, 32'h1, 32'h1, "rd_lane1_down");

        // Lane 2 link drops: 3, then 5 total (2-bit counter saturates at 3)
        raw_link_up[2] = 1'b1; step(16);
        for (int k = 0; k < 3; k++) begin
            raw_link_up[2] = 1'b0; step(1);
            raw_link_up[2] = 1'b1; step(16);
        end
        chk("lane2_up", {28'b0, a_link_up}, 32'h4);
        rd(8'h2C, 32'd3, 32'd3, "rd_down3");
        for (int k = 0; k < 2; k++) begin
            raw_link_up[2] = 1'b0; step(1);
            raw_link_up[2] = 1'b1; step(16);
        end
        rd(8'h2C, 32'd5, 32'd3, "rd_down_sat");

        // Lane 3 packets, wrap and clear-vs-increment
        rx_pkts(3, 5);
        tx_pkts(3, 2);
        rd(8'h34, 32'd5, 32'd1, "rd_rx_wrap");
        rd(8'h38, 32'd2, 32'd2, "rd_tx");
        e2v_tvalid[3] = 1'b1; e2v_tready[3] = 1'b1; e2v_tlast[3] = 1'b1;
        clr_counters = 1'b1;
        step(1);
        e2v_tvalid[3] = 1'b0; e2v_tready[3] = 1'b0; e2v_tlast[3] = 1'b0;
        clr_counters = 1'b0;
        rd(8'h34, 32'd0, 32'd0, "rd_rx_clr_wins");
        rd(8'h2C, 32'd0, 32'd0, "rd_down_clr");
        chk("clr_keeps_link", {28'b0, a_link_up}, 32'h4);

        // Non-tlast beat and tlast without tready must not count
        e2v_tvalid[3] = 1'b1; e2v_tready[3] = 1'b1; e2v_tlast[3] = 1'b0; step(1);
        e2v_tready[3] = 1'b0; e2v_tlast[3] = 1'b1; step(1);
        e2v_tvalid[3] = 1'b0; e2v_tlast[3] = 1'b0;
        rx_pkts(3, 3);
        rd(8'h34, 32'd3, 32'd3, "rd_rx_after_clr");
        rd(8'h30, 32'h2, 32'h2, "rd_lane3_active");
        step(20);
        chk("act_idle", {28'b0, a_activity}, 32'h0);

        // Increment on the request cycle is not visible in that read
        e2v_tvalid[3] = 1'b1; e2v_tready[3] = 1'b1; e2v_tlast[3] = 1'b1;
        reg_rd_req = 1'b1; reg_rd_addr = 8'h34;
        step(1);
        e2v_tvalid[3] = 1'b0; e2v_tready[3] = 1'b0; e2v_tlast[3] = 1'b0;
        reg_rd_req = 1'b0;
        chk("rd_coincident", a_data, 32'd3);
        chk("rd_coincident_w2", b_data, 32'd3);
        step(1);
        rd(8'h34, 32'd4, 32'd0, "rd_after_inc");
        step(20);

        // Activity stretch on lane 0
        tx_beat0();
        chk("act_start", {28'b0, a_activity}, 32'h1);
        step(7);
        chk("act_hold_end", {28'b0, a_activity}, 32'h1);
        step(1);
        chk("act_expire", {28'b0, a_activity}, 32'h0);
        tx_beat0();
        step(6);
        tx_beat0();
        chk("act_reload", {28'b0, a_activity}, 32'h1);
        step(7);
        chk("act_ext_end", {28'b0, a_activity}, 32'h1);
        step(1);
        chk("act_ext_expire", {28'b0, a_activity}, 32'h0);

        // Out-of-range lanes
        rd(8'h50, 32'hDEAD_0004, 32'hDEAD_0004, "rd_bad_lane5");
        rd(8'hF4, 32'hDEAD_0004, 32'hDEAD_0004, "rd_bad_lane15");

        // Back-to-back reads
        reg_rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            reg_rd_addr = b2b_addr[k];
            step(1);
            chk("b2b_ack", {31'b0, a_ack}, 32'd1);
            chk("b2b_data", a_data, b2b_exp[k]);
            chk("b2b_data_w2", b_data, b2b_exp2[k]);
        end
        reg_rd_req = 1'b0;
        reg_rd_addr = 8'h20;
        step(1);
        chk("b2b_ack_drop", {31'b0, a_ack}, 32'd0);
        chk("b2b_data_hold", a_data, 32'h4);

        // Reset with a read pending
        reg_rd_req = 1'b1; reg_rd_addr = 8'h34;
        bus_rst = 1'b1;
        step(1);
        chk("midrst_ack", {31'b0, a_ack}, 32'd0);
        chk("midrst_data", a_data, 32'd0);
        chk("midrst_link", {28'b0, a_link_up}, 32'h0);
        bus_rst = 1'b0; reg_rd_req = 1'b0;
        step(1);
        chk("midrst_no_ack", {31'b0, a_ack}, 32'd0);
        rd(8'h34, 32'd0, 32'd0, "rd_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
